uart_fifo_bridge: RTL and testbench

- Buffers bytes between the J1a CPU I/O decode and the UART register-sequencing wrapper.
- CPU writes go into a TX FIFO; the bridge drains it into the wrapper's tx_req/tx_busy handshake.
- The bridge pulls bytes from the wrapper's rx_valid/rx_req handshake into an RX FIFO, which the CPU pops at leisure.
- Removes the wrapper's single-byte RX holding limit, so RX characters are not dropped while Forth code is busy.

---
 rtl/uart_pkg.sv | 10 +
 rtl/byte_fifo.sv | 40 ++++
 rtl/uart_fifo_bridge.sv | 94 +++++++++
 tb/tb_uart_fifo_bridge.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared constants, status bit positions and FSM encodings for the UART FIFO bridge
package uart_pkg;
    localparam int DEF_DEPTH_LOG2 = 4;
    localparam int ST_TX_FULL  = 0;
    localparam int ST_RX_EMPTY = 1;
    localparam int ST_TX_OVF   = 2;
    localparam int ST_RX_OVF   = 3;
    typedef enum logic [1:0] {TX_IDLE = 2'd0, TX_REQ = 2'd1, TX_HOLD = 2'd2} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE = 2'd0, RX_ACK = 2'd1} rx_state_t;
endpackage

// File: rtl/byte_fifo.sv
// byte_fifo: register-based show-ahead byte FIFO with registered occupancy count
module byte_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH_LOG2 = DEF_DEPTH_LOG2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                push,
    input  logic [7:0]          din,
    input  logic                pop,
    output logic [7:0]          dout,
    output logic                full,
    output logic                empty,
    output logic [DEPTH_LOG2:0] count
);
    logic [7:0] mem [1 << DEPTH_LOG2];
    logic [DEPTH_LOG2-1:0] wp, rp;
    logic do_push, do_pop;
    assign full    = count[DEPTH_LOG2];
    assign empty   = count == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    // empty head reads as zero so the output is defined out of reset
    assign dout    = empty ? 8'h00 : mem[rp];
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (do_push) wp <= wp + 1'b1;
            if (do_pop) rp <= rp + 1'b1;
            if (do_push != do_pop) count <= do_push ? count + 1'b1 : count - 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem[wp] <= din;
    end
endmodule

// File: rtl/uart_fifo_bridge.sv
// uart_fifo_bridge: TX/RX byte FIFOs between the CPU I/O decode and the UART wrapper handshakes
module uart_fifo_bridge
    import uart_pkg::*;
#(
    parameter int DEPTH_LOG2 = DEF_DEPTH_LOG2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cpu_wr,
    input  logic [7:0]          cpu_wdata,
    input  logic                cpu_rd,
    output logic [7:0]          cpu_rdata,
    input  logic                clr_err,
    output logic [7:0]          status,
    output logic [DEPTH_LOG2:0] tx_count,
    output logic [DEPTH_LOG2:0] rx_count,
    output logic                tx_req,
    output logic [7:0]          tx_data,
    input  logic                tx_busy,
    input  logic                rx_valid,
    input  logic [7:0]          rx_data,
    output logic                rx_req
);
    localparam logic [DEPTH_LOG2:0] STALL_LAST = (DEPTH_LOG2+1)'((1 << DEPTH_LOG2) - 1);
    logic tx_full, tx_empty, tx_pop, rx_full, rx_empty, rx_push;
    logic tx_ovf, rx_ovf, stall, rx_ovf_set;
    logic [7:0] tx_head;
    logic [DEPTH_LOG2:0] stall_cnt;
    tx_state_t tx_state, tx_next;
    rx_state_t rx_state, rx_next;

    byte_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_tx_fifo (
        .clk(clk), .rst(rst), .push(cpu_wr), .din(cpu_wdata), .pop(tx_pop),
        .dout(tx_head), .full(tx_full), .empty(tx_empty), .count(tx_count)
    );
    byte_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_rx_fifo (
        .clk(clk), .rst(rst), .push(rx_push), .din(rx_data), .pop(cpu_rd),
        .dout(cpu_rdata), .full(rx_full), .empty(rx_empty), .count(rx_count)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_state <= TX_IDLE;
            rx_state <= RX_IDLE;
        end else begin
            tx_state <= tx_next;
            rx_state <= rx_next;
        end
    end

    // TX_REQ ignores tx_busy: the wrapper only raises it one cycle after the request
    always_comb begin
        tx_next = tx_state == TX_IDLE ? (tx_pop ? TX_REQ : TX_IDLE) :
                  tx_state == TX_REQ  ? TX_HOLD :
                  tx_busy             ? TX_HOLD : TX_IDLE;
        rx_next = rx_push ? RX_ACK : RX_IDLE;
    end

    always_comb begin
        tx_pop  = tx_state == TX_IDLE && !tx_empty && !tx_busy;
        tx_req  = tx_state == TX_REQ;
        rx_push = rx_state == RX_IDLE && rx_valid && !rx_full;
        rx_req  = rx_state == RX_ACK;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) tx_data <= '0;
        else if (tx_pop) tx_data <= tx_head;
    end

    // back-pressure watchdog: rx_valid refused for a full FIFO depth worth of cycles
    assign stall      = rx_state == RX_IDLE && rx_valid && rx_full;
    assign rx_ovf_set = stall && stall_cnt == STALL_LAST;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
            tx_ovf    <= 1'b0;
            rx_ovf    <= 1'b0;
        end else begin
            stall_cnt <= !stall ? '0 : stall_cnt[DEPTH_LOG2] ? stall_cnt : stall_cnt + 1'b1;
            tx_ovf    <= (cpu_wr && tx_full) || (tx_ovf && !clr_err);
            rx_ovf    <= rx_ovf_set || (rx_ovf && !clr_err);
        end
    end

    always_comb begin
        status              = '0;
        status[ST_TX_FULL]  = tx_full;
        status[ST_RX_EMPTY] = rx_empty;
        status[ST_TX_OVF]   = tx_ovf;
        status[ST_RX_OVF]   = rx_ovf;
    end
endmodule

// File: tb/tb_uart_fifo_bridge.sv
// tb_uart_fifo_bridge: directed checks of the UART FIFO bridge with a small wrapper model
module tb_uart_fifo_bridge;
    import uart_pkg::*;
    localparam int DL = 4;

    typedef struct {
        logic       wr;
        logic [7:0] wdata;
        logic       clr;
        int         exp_cnt;
        logic [7:0] exp_st;
    } vec_t;

    logic clk = 0, rst = 0, cpu_wr = 0, cpu_rd = 0, clr_err = 0, rx_valid = 0;
    logic tx_busy, tx_req, rx_req;
    logic [7:0] cpu_wdata = 0, rx_data = 0, cpu_rdata, status, tx_data;
    logic [DL:0] tx_count, rx_count;
    int checks = 0, errors = 0, busy_cnt = 0, cyc = 0, last_req = -100, rx_pulses = 0;
    bit busy_hold = 0;
    logic [7:0] txq[$];
    vec_t vecs[20];

    uart_fifo_bridge #(.DEPTH_LOG2(DL)) dut (
        .clk(clk), .rst(rst), .cpu_wr(cpu_wr), .cpu_wdata(cpu_wdata), .cpu_rd(cpu_rd),
        .cpu_rdata(cpu_rdata), .clr_err(clr_err), .status(status), .tx_count(tx_count),
        .rx_count(rx_count), .tx_req(tx_req), .tx_data(tx_data), .tx_busy(tx_busy),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_req(rx_req)
    );

    always #5 clk = ~clk;

    // wrapper model: busy for 5 cycles after each request, records transmitted bytes
    assign tx_busy = busy_hold || (busy_cnt != 0);
    always @(posedge clk) begin
        #1;
        cyc++;
        if (tx_req) begin
            checks++;
            if (cyc - last_req < 3) begin
                errors++;
                $display("FAIL tx_req_spacing got %0d cycles want >=3", cyc - last_req);
            end
            last_req = cyc;
            txq.push_back(tx_data);
            busy_cnt = 5;
        end else if (busy_cnt > 0) busy_cnt--;
        if (rx_req) rx_pulses++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [7:0] d);
        cpu_wr = 1; cpu_wdata = d;
        tick();
        cpu_wr = 0;
    endtask

    task automatic rx_send(input logic [7:0] d);
        int n;
        n = 0;
        rx_valid = 1; rx_data = d;
        while (!rx_req && n < 20) begin tick(); n++; end
        chk("rx_send_ack", 32'(rx_req), 1);
        tick();
        rx_valid = 0;
    endtask

    task automatic pop_check(input logic [7:0] exp);
        chk("rx_head", 32'(cpu_rdata), 32'(exp));
        cpu_rd = 1;
        tick();
        cpu_rd = 0;
    endtask

    initial begin
        int n, p0;
        for (int i = 0; i < 16; i++) vecs[i] = '{1'b1, 8'(i), 1'b0, i + 1, (i == 15) ? 8'h03 : 8'h02};
        vecs[16] = '{1'b1, 8'h10, 1'b0, 16, 8'h07};
        vecs[17] = '{1'b0, 8'h00, 1'b1, 16, 8'h03};
        vecs[18] = '{1'b1, 8'h10, 1'b1, 16, 8'h07};
        vecs[19] = '{1'b0, 8'h00, 1'b1, 16, 8'h03};

        repeat (3) tick();
        rst = 1;
        tick();
        chk("rst_tx_req", 32'(tx_req), 0);
        chk("rst_rx_req", 32'(rx_req), 0);
        chk("rst_tx_data", 32'(tx_data), 0);
        chk("rst_cpu_rdata", 32'(cpu_rdata), 0);
        chk("rst_status", 32'(status), 32'h02);
        chk("rst_tx_count", 32'(tx_count), 0);
        chk("rst_rx_count", 32'(rx_count), 0);

        busy_hold = 1;
        wr(8'h41);
        wr(8'h42);
        chk("t1_count2", 32'(tx_count), 2);
        busy_hold = 0;
        tick();
        chk("t1_count1", 32'(tx_count), 1);
        chk("t1_req", 32'(tx_req), 1);
        chk("t1_data", 32'(tx_data), 32'h41);
        n = 0;
        while (tx_count != 0 && n < 20) begin tick(); n++; end
        chk("t1_count0", 32'(tx_count), 0);
        n = 0;
        while (txq.size() < 2 && n < 20) begin tick(); n++; end
        chk("t1_nbytes", txq.size(), 2);
        chk("t1_byte0", txq.size() > 0 ? 32'(txq[0]) : 32'hffff, 32'h41);
        chk("t1_byte1", txq.size() > 1 ? 32'(txq[1]) : 32'hffff, 32'h42);
        repeat (10) tick();
        txq.delete();

        busy_hold = 1;
        for (int i = 0; i < 20; i++) begin
            cpu_wr = vecs[i].wr; cpu_wdata = vecs[i].wdata; clr_err = vecs[i].clr;
            tick();
            cpu_wr = 0; clr_err = 0;
            chk($sformatf("vec%0d_count", i), 32'(tx_count), 32'(vecs[i].exp_cnt));
            chk($sformatf("vec%0d_status", i), 32'(status), 32'(vecs[i].exp_st));
        end
        busy_hold = 0;
        n = 0;
        while (txq.size() < 16 && n < 400) begin tick(); n++; end
        chk("drain_nbytes", txq.size(), 16);
        for (int i = 0; i < 16; i++)
            chk($sformatf("drain_byte%0d", i), i < txq.size() ? 32'(txq[i]) : 32'hffff, 32'(i));
        repeat (20) tick();
        chk("drain_no_extra", txq.size(), 16);
        chk("drain_count", 32'(tx_count), 0);
        chk("drain_status", 32'(status), 32'h02);

        p0 = rx_pulses;
        rx_send(8'h55);
        tick();
        chk("rx1_pulses", rx_pulses - p0, 1);
        chk("rx1_count", 32'(rx_count), 1);
        chk("rx1_rdata", 32'(cpu_rdata), 32'h55);
        chk("rx1_status", 32'(status), 32'h00);
        cpu_rd = 1; tick(); cpu_rd = 0;
        chk("rx1_empty", 32'(status[ST_RX_EMPTY]), 1);
        chk("rx1_count0", 32'(rx_count), 0);
        cpu_rd = 1; tick(); cpu_rd = 0;
        chk("rx_empty_pop_count", 32'(rx_count), 0);
        chk("rx_empty_pop_status", 32'(status), 32'h02);

        for (int i = 0; i < 16; i++) rx_send(8'hA0 + 8'(i));
        chk("rxf_count16", 32'(rx_count), 16);
        p0 = rx_pulses;
        rx_valid = 1; rx_data = 8'hEE;
        repeat (15) tick();
        chk("rxf_ovf_early", 32'(status[ST_RX_OVF]), 0);
        tick();
        chk("rxf_ovf_set", 32'(status[ST_RX_OVF]), 1);
        chk("rxf_no_ack", rx_pulses - p0, 0);
        cpu_rd = 1; tick(); cpu_rd = 0;
        chk("rxf_count15", 32'(rx_count), 15);
        n = 0;
        while (!rx_req && n < 2) begin tick(); n++; end
        chk("rxf_ack_in2", 32'(rx_req), 1);
        tick();
        rx_valid = 0;
        tick();
        chk("rxf_pulses", rx_pulses - p0, 1);
        chk("rxf_count16b", 32'(rx_count), 16);
        chk("rxf_status_sticky", 32'(status), 32'h08);
        clr_err = 1; tick(); clr_err = 0;
        chk("rxf_clr", 32'(status), 32'h00);
        for (int i = 1; i < 12; i++) pop_check(8'hA0 + 8'(i));
        chk("sim_count5", 32'(rx_count), 5);

        rx_valid = 1; rx_data = 8'h77; cpu_rd = 1;
        tick();
        cpu_rd = 0;
        chk("sim_count_same", 32'(rx_count), 5);
        chk("sim_head", 32'(cpu_rdata), 32'hAD);
        tick();
        rx_valid = 0;
        tick();
        pop_check(8'hAD);
        pop_check(8'hAE);
        pop_check(8'hAF);
        pop_check(8'hEE);
        pop_check(8'h77);
        chk("sim_empty", 32'(status), 32'h02);

        txq.delete();
        wr(8'h90);
        n = 0;
        while (!tx_req && n < 10) begin tick(); n++; end
        chk("rst_mid_req", 32'(tx_req), 1);
        busy_hold = 1;
        wr(8'h91);
        wr(8'h92);
        wr(8'h93);
        rx_send(8'h33);
        chk("rst_mid_txcnt", 32'(tx_count), 3);
        chk("rst_mid_rxcnt", 32'(rx_count), 1);
        #2;
        rst = 0;
        #1;
        chk("rst_async_req", 32'(tx_req), 0);
        chk("rst_async_txcnt", 32'(tx_count), 0);
        chk("rst_async_rxcnt", 32'(rx_count), 0);
        chk("rst_async_status", 32'(status), 32'h02);
        tick();
        rst = 1;
        busy_hold = 0;
        n = txq.size();
        repeat (20) tick();
        chk("rst_no_req", txq.size(), n);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
